// File: rtl/gpio_p2s_pkg.sv
// Shared definitions for the GPIO parallel-to-serial block.
// Holds the 2-bit FSM state encoding and the default parameter values,
// so the top, its sub-module and any wrapper agree on one set of constants.
package gpio_p2s_pkg;

  // FSM state encoding (2 bits)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  // Parameter defaults
  localparam int DEF_DATA_BITS = 16;
  localparam int DEF_DIV_LOG2  = 1;
  localparam int DEF_INVERT    = 1;
  localparam int DEF_REVERSE   = 1;
  localparam int DEF_AUTO      = 0;

endpackage

// File: rtl/gpio_p2s_tick_gen.sv
// Purpose: free-running divider, one-clk tick every 2**DIV_LOG2 clk cycles.
// Latency: first tick 2**DIV_LOG2 clk after clr drops; tick is combinational from the count.
// Backpressure: none; clr holds the count at zero.
// Ports: clk, rst (async, active-high), clr (sync clear), tick (1-clk pulse).
module tick_gen #(
  parameter int DIV_LOG2 = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  // Keep at least one counter bit so DIV_LOG2=0 still elaborates;
  // in that case CNT_MAX is 0 and tick is permanently high.
  localparam int            CW      = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << DIV_LOG2) - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick = (cnt_q == CNT_MAX);
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpio_p2s.sv
// Purpose: GPIO register whose contents are shifted out to an external serial-in/parallel-out register.
// Latency: frame = 1 + (2*DATA_BITS+1) * 2**DIV_LOG2 clk from LOAD back to IDLE; all outputs registered.
// Backpressure: none; start/auto-writes while busy collapse into one pending frame sent right after.
// Ports: clk, rst (async, active-high), en/p_data (register write), start (frame request),
//        gpio_out (register), sclk/sout/clrn/pen (serial interface), busy (frame in progress).
module gpio_p2s
  import gpio_p2s_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int DIV_LOG2  = DEF_DIV_LOG2,
  parameter int INVERT    = DEF_INVERT,
  parameter int REVERSE   = DEF_REVERSE,
  parameter int AUTO      = DEF_AUTO
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATA_BITS-1:0] p_data,
  input  logic                 start,
  output logic [DATA_BITS-1:0] gpio_out,
  output logic                 sclk,
  output logic                 sout,
  output logic                 clrn,
  output logic                 pen,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  logic [1:0]           state_q,   state_d;
  logic [DATA_BITS-1:0] gpio_q,    gpio_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 pending_q, pending_d;
  logic                 sclk_q,    sclk_d;
  logic                 sout_q,    sout_d;
  logic                 pen_q,     pen_d;
  logic                 busy_q,    busy_d;
  logic                 clrn_q;

  logic                 tick;
  logic                 tick_clr;
  logic                 auto_wr;
  logic                 frame_req;
  logic [DATA_BITS-1:0] src;
  logic [DATA_BITS-1:0] snap;

  // Divider only runs while the serial interface is active, so the first
  // tick of SHIFT lands a full period after LOAD.
  assign tick_clr = (state_q != ST_SHIFT) && (state_q != ST_LATCH);

  tick_gen #(.DIV_LOG2(DIV_LOG2)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign auto_wr   = (AUTO != 0) && en;
  assign frame_req = start || auto_wr;

  // Snapshot source is write-first: a write in the launch cycle is what gets sent.
  // The shifter emits its MSB first, so REVERSE places gpio[0] at the MSB.
  always_comb begin
    src = en ? p_data : gpio_q;
    for (int i = 0; i < DATA_BITS; i++) begin
      snap[i] = (REVERSE != 0) ? src[DATA_BITS-1-i] : src[i];
    end
    if (INVERT != 0) begin
      snap = ~snap;
    end
  end

  always_comb begin
    state_d   = state_q;
    gpio_d    = en ? p_data : gpio_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pending_d = pending_q;
    sclk_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_req || pending_q) begin
          state_d   = ST_LOAD;
          shift_d   = snap;
          bit_cnt_d = '0;
          pending_d = 1'b0;
        end
      end
      ST_LOAD: begin
        state_d   = ST_SHIFT;
        pending_d = pending_q || frame_req;
      end
      ST_SHIFT: begin
        pending_d = pending_q || frame_req;
        sclk_d    = tick ? ~sclk_q : sclk_q;
        // Falling sclk edge: advance to the next bit; after the last bit go latch.
        if (tick && sclk_q) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        pending_d = pending_q || frame_req;
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next-state view so they line up with state_q.
    busy_d = (state_d != ST_IDLE);
    pen_d  = (state_d == ST_LATCH);
    sout_d = (state_d == ST_SHIFT) ? shift_d[DATA_BITS-1] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gpio_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      pending_q <= 1'b0;
      sclk_q    <= 1'b0;
      sout_q    <= 1'b0;
      pen_q     <= 1'b0;
      busy_q    <= 1'b0;
      clrn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gpio_q    <= gpio_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      pending_q <= pending_d;
      sclk_q    <= sclk_d;
      sout_q    <= sout_d;
      pen_q     <= pen_d;
      busy_q    <= busy_d;
      clrn_q    <= 1'b1;
    end
  end

  assign gpio_out = gpio_q;
  assign sclk     = sclk_q;
  assign sout     = sout_q;
  assign clrn     = clrn_q;
  assign pen      = pen_q;
  assign busy     = busy_q;

endmodule
